// File: rtl/helm_msg_ctrl.sv
// helm_msg_ctrl: buffers a helm UART message and executes it as user-memory block/byte writes, block reads and write-verify.
// Optional HELM_MSG_PAGE_CARRY_EN: an offset wrap 0xFF->0x00 also increments the page.
module helm_msg_ctrl #(
  parameter int         DW               = 8,
  parameter int         AW               = 8,
  parameter logic [7:0] C_MSG_BLK_WRITE  = 8'h00,
  parameter logic [7:0] C_MSG_BYTE_WRITE = 8'h01,
  parameter logic [7:0] C_MSG_BLK_READ   = 8'h02,
  parameter logic [7:0] C_MSG_BLK_WR_VER = 8'h03
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [7:0]    msg_type,
  input  logic [7:0]    msg_page,
  input  logic [7:0]    msg_offset,
  input  logic          msg_exec,
  input  logic          msg_chksum_err,
  input  logic          msg_data_wr,
  input  logic [AW-1:0] msg_data_adr,
  input  logic [DW-1:0] msg_data,
  input  logic          usr_mem_rdy,
  input  logic [DW-1:0] usr_mem_rd_data,
  output logic          usr_mem_wr_en,
  output logic          usr_mem_rd_en,
  output logic [7:0]    usr_mem_page,
  output logic [7:0]    usr_mem_offset,
  output logic [DW-1:0] usr_mem_wr_data,
  output logic [DW-1:0] usr_mem_wr_msk,
  output logic          tx_blkwr,
  output logic          tx_blkrd,
  output logic [7:0]    data_len,
  output logic          busy,
  output logic          ver_err
);
  localparam logic [AW-1:0] P_LEN = AW'(2);
  localparam logic [AW-1:0] P_PAY = AW'(3);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_BYTE, S_RD, S_VRD, S_VCMP, S_RSP} state_t;
  state_t r_state, w_next;
  logic [DW-1:0] r_buf [2**AW];
  logic [7:0] r_page, r_off, r_page0, r_off0, r_len, r_cnt, r_data_len;
  logic [AW-1:0] r_ptr, r_cmp_ptr;
  logic r_ver, r_rd, r_ver_err, r_cmp_pend;
  logic w_acc, w_rbeat, w_step, w_reload;
  logic [7:0] w_len, w_page_inc;
  assign w_len = r_buf[P_LEN][7:0];
  assign w_acc = r_state == S_IDLE && msg_exec && !msg_chksum_err &&
                 (msg_type inside {C_MSG_BLK_WRITE, C_MSG_BYTE_WRITE, C_MSG_BLK_READ, C_MSG_BLK_WR_VER});
  assign w_rbeat = usr_mem_rd_en && usr_mem_rdy;
  assign w_step = (r_state == S_WR && usr_mem_rdy) || w_rbeat;
  assign w_reload = r_state == S_WR && w_next == S_VRD;
  assign usr_mem_page = r_page;
  assign usr_mem_offset = r_off;
  assign data_len = r_data_len;
  assign ver_err = r_ver_err;
`ifdef HELM_MSG_PAGE_CARRY_EN
  assign w_page_inc = r_off == 8'hFF ? r_page + 8'd1 : r_page;
`else
  assign w_page_inc = r_page;
`endif
  always_ff @(posedge clk)
    if (msg_data_wr && !busy) r_buf[msg_data_adr] <= msg_data;
  always_ff @(posedge clk)
    r_state <= !rst_b ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    busy = r_state != S_IDLE;
    usr_mem_wr_en = r_state == S_WR || r_state == S_BYTE;
    usr_mem_rd_en = r_state == S_VRD && r_cnt != 8'd0;
    usr_mem_wr_data = !usr_mem_wr_en ? '0 : r_state == S_BYTE ? r_buf[P_LEN] : r_buf[r_ptr];
    usr_mem_wr_msk = !usr_mem_wr_en ? '0 : r_state == S_BYTE ? r_buf[P_PAY] : '1;
    tx_blkwr = r_state == S_RSP && !r_rd;
    tx_blkrd = r_state == S_RSP && r_rd;
    case (r_state)
      S_IDLE: if (w_acc) w_next = msg_type == C_MSG_BYTE_WRITE ? S_BYTE :
                                  msg_type == C_MSG_BLK_READ ? S_RD :
                                  w_len != 8'd0 ? S_WR :
                                  msg_type == C_MSG_BLK_WR_VER ? S_VRD : S_RSP;
      S_WR:   if (usr_mem_rdy && r_cnt == 8'd1) w_next = r_ver ? S_VRD : S_RSP;
      S_BYTE: if (usr_mem_rdy) w_next = S_RSP;
      S_RD:   w_next = S_RSP;
      S_VRD:  if (r_cnt == 8'd0 || (usr_mem_rdy && r_cnt == 8'd1)) w_next = S_VCMP;
      S_VCMP: w_next = S_RSP;
      default: w_next = S_IDLE;
    endcase
  end
  // read data returns one cycle after acceptance, so the compare trails the read by one cycle
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      {r_page, r_off, r_page0, r_off0, r_len, r_cnt, r_data_len} <= '0;
      r_ptr <= '0;
      r_cmp_ptr <= '0;
      {r_ver, r_rd, r_ver_err, r_cmp_pend} <= '0;
    end else if (w_acc) begin
      r_page <= msg_page;
      r_page0 <= msg_page;
      r_off <= msg_offset;
      r_off0 <= msg_offset;
      r_len <= w_len;
      r_cnt <= w_len;
      r_ptr <= P_PAY;
      r_ver <= msg_type == C_MSG_BLK_WR_VER;
      r_rd <= msg_type == C_MSG_BLK_READ;
      r_data_len <= msg_type == C_MSG_BYTE_WRITE ? 8'd1 : w_len;
      r_ver_err <= 1'b0;
      r_cmp_pend <= 1'b0;
    end else begin
      r_cmp_pend <= w_rbeat;
      if (w_rbeat) r_cmp_ptr <= r_ptr;
      if (r_cmp_pend && usr_mem_rd_data != r_buf[r_cmp_ptr]) r_ver_err <= 1'b1;
      if (w_reload) begin
        r_page <= r_page0;
        r_off <= r_off0;
        r_ptr <= P_PAY;
        r_cnt <= r_len;
      end else if (w_step) begin
        r_page <= w_page_inc;
        r_off <= r_off + 8'd1;
        r_ptr <= r_ptr + AW'(1);
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_helm_msg_ctrl.sv
// tb_helm_msg_ctrl: randomized bench for helm_msg_ctrl against a transaction-level model of each message.
module tb_helm_msg_ctrl;
  localparam logic [7:0] T_WR = 8'h00, T_BYTE = 8'h01, T_RD = 8'h02, T_VER = 8'h03;
  logic clk = 0, rst_b = 0;
  logic [7:0] msg_type = 0, msg_page = 0, msg_offset = 0, msg_data_adr = 0, msg_data = 0;
  logic msg_exec = 0, msg_chksum_err = 0, msg_data_wr = 0, usr_mem_rdy = 0;
  logic [7:0] usr_mem_rd_data = 0;
  logic usr_mem_wr_en, usr_mem_rd_en, tx_blkwr, tx_blkrd, busy, ver_err;
  logic [7:0] usr_mem_page, usr_mem_offset, usr_mem_wr_data, usr_mem_wr_msk, data_len;
  always #5 clk = ~clk;
  helm_msg_ctrl dut (
    .clk(clk), .rst_b(rst_b), .msg_type(msg_type), .msg_page(msg_page), .msg_offset(msg_offset),
    .msg_exec(msg_exec), .msg_chksum_err(msg_chksum_err), .msg_data_wr(msg_data_wr),
    .msg_data_adr(msg_data_adr), .msg_data(msg_data), .usr_mem_rdy(usr_mem_rdy),
    .usr_mem_rd_data(usr_mem_rd_data), .usr_mem_wr_en(usr_mem_wr_en), .usr_mem_rd_en(usr_mem_rd_en),
    .usr_mem_page(usr_mem_page), .usr_mem_offset(usr_mem_offset), .usr_mem_wr_data(usr_mem_wr_data),
    .usr_mem_wr_msk(usr_mem_wr_msk), .tx_blkwr(tx_blkwr), .tx_blkrd(tx_blkrd), .data_len(data_len),
    .busy(busy), .ver_err(ver_err)
  );
  int n_chk = 0, n_err = 0;
  logic [7:0] bm [256];
  logic [7:0] mem [int];
  logic [31:0] wq[$], exp_w[$];
  logic [15:0] rq[$], exp_r[$];
  logic [10:0] rspq[$];
  int rdy_pct = 100, stall_n = 0, bad_idx = -1, rd_idx = 0, pend_idx = 0;
  bit rd_pend = 0, waiting = 0;
  int pend_adr = 0;
  logic [33:0] prev_sig = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] rd_mem(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction
  function automatic logic [63:0] outs();
    return {18'd0, usr_mem_wr_en, usr_mem_rd_en, tx_blkwr, tx_blkrd, busy, ver_err,
            usr_mem_page, usr_mem_offset, usr_mem_wr_data, usr_mem_wr_msk, data_len};
  endfunction
  function automatic logic [7:0] pg_at(input logic [7:0] pg, input int s);
`ifdef HELM_MSG_PAGE_CARRY_EN
    return 8'(int'(pg) + s / 256);
`else
    return pg;
`endif
  endfunction
  // one clock: behaves as the user memory (ready, read data) and logs every completed transaction
  task automatic tick();
    logic [33:0] sig;
    int a;
    @(negedge clk);
    usr_mem_rd_data = rd_pend ? rd_mem(pend_adr) ^ (pend_idx == bad_idx ? 8'h01 : 8'h00) : 8'($urandom);
    sig = {usr_mem_wr_en, usr_mem_rd_en, usr_mem_page, usr_mem_offset, usr_mem_wr_data, usr_mem_wr_msk};
    if (waiting && rst_b) chk("hold", 64'(sig), 64'(prev_sig));
    if ((usr_mem_wr_en || usr_mem_rd_en) && stall_n > 0) begin
      usr_mem_rdy = 0;
      stall_n--;
    end else usr_mem_rdy = $urandom_range(99) < rdy_pct;
    waiting = (usr_mem_wr_en || usr_mem_rd_en) && !usr_mem_rdy;
    prev_sig = sig;
    rd_pend = 0;
    a = int'({usr_mem_page, usr_mem_offset});
    if (usr_mem_wr_en && usr_mem_rdy) begin
      mem[a] = (rd_mem(a) & ~usr_mem_wr_msk) | (usr_mem_wr_data & usr_mem_wr_msk);
      wq.push_back({usr_mem_page, usr_mem_offset, usr_mem_wr_data, usr_mem_wr_msk});
    end
    if (usr_mem_rd_en && usr_mem_rdy) begin
      rq.push_back({usr_mem_page, usr_mem_offset});
      rd_pend = 1;
      pend_adr = a;
      pend_idx = rd_idx++;
    end
    if (tx_blkwr || tx_blkrd) rspq.push_back({tx_blkwr, tx_blkrd, data_len, ver_err});
  endtask
  task automatic wbuf(input int a, input logic [7:0] v);
    msg_data_wr = 1;
    msg_data_adr = 8'(a);
    msg_data = v;
    bm[a] = v;
    tick();
    msg_data_wr = 0;
  endtask
  task automatic run_msg(input logic [7:0] typ, input logic [7:0] pg, input logic [7:0] of,
                         input bit cerr, input bit poke);
    bit acc, ver;
    int len, s, cyc;
    logic [7:0] dl;
    wq.delete(); rq.delete(); rspq.delete(); exp_w.delete(); exp_r.delete();
    rd_idx = 0;
    acc = !cerr && typ <= T_VER;
    len = int'(bm[2]);
    dl = bm[2];
    ver = 0;
    if (acc && (typ == T_WR || typ == T_VER))
      for (int i = 0; i < len; i++) begin
        s = int'(of) + i;
        exp_w.push_back({pg_at(pg, s), 8'(s), bm[8'(3 + i)], 8'hFF});
        if (typ == T_VER) begin
          exp_r.push_back({pg_at(pg, s), 8'(s)});
          ver |= (i == bad_idx);
        end
      end
    if (acc && typ == T_BYTE) begin
      exp_w.push_back({pg, of, bm[2], bm[3]});
      dl = 8'd1;
    end
    msg_type = typ; msg_page = pg; msg_offset = of; msg_chksum_err = cerr; msg_exec = 1;
    tick();
    msg_exec = 0; msg_chksum_err = 0;
    chk("busy", 64'(busy), 64'(acc));
    if (poke) begin
      msg_exec = 1; msg_type = T_RD; msg_data_wr = 1; msg_data_adr = 8'd4; msg_data = 8'hEE;
      tick();
      msg_exec = 0; msg_data_wr = 0; msg_type = typ;
    end
    cyc = 0;
    while (busy && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("done", 64'(busy), 64'd0);
    tick();
    tick();
    chk("rsp_n", 64'(rspq.size()), 64'(acc));
    if (acc) chk("rsp", 64'(rspq.size() > 0 ? rspq[0] : 11'h7FF), 64'({typ != T_RD, typ == T_RD, dl, ver}));
    chk("wr_n", 64'(wq.size()), 64'(exp_w.size()));
    foreach (exp_w[i]) chk("wr", 64'(i < wq.size() ? wq[i] : 32'hFFFFFFFF), 64'(exp_w[i]));
    chk("rd_n", 64'(rq.size()), 64'(exp_r.size()));
    foreach (exp_r[i]) chk("rd", 64'(i < rq.size() ? rq[i] : 16'hFFFF), 64'(exp_r[i]));
  endtask
  initial begin
    logic [7:0] typ, pg, of;
    int len;
    bit cerr;
    repeat (3) tick();
    chk("reset", outs(), 64'd0);
    rst_b = 1;
    tick();
    wbuf(2, 8'd3); wbuf(3, 8'hA1); wbuf(4, 8'hB2); wbuf(5, 8'hC3);
    run_msg(T_WR, 8'h04, 8'h10, 0, 0);
    wbuf(2, 8'h5A); wbuf(3, 8'h0F);
    run_msg(T_BYTE, 8'h21, 8'h40, 0, 0);
    run_msg(T_WR, 8'h01, 8'h02, 1, 0);
    run_msg(8'h07, 8'h01, 8'h02, 0, 0);
    wbuf(2, 8'd2); wbuf(3, 8'h3C); wbuf(4, 8'h7E);
    stall_n = 3;
    run_msg(T_WR, 8'h10, 8'h80, 0, 1);
    chk("stall", 64'(stall_n), 64'd0);
    wbuf(2, 8'd2); wbuf(3, 8'h11); wbuf(4, 8'h22);
    bad_idx = 1;
    run_msg(T_VER, 8'h33, 8'h50, 0, 0);
    bad_idx = -1;
    run_msg(T_VER, 8'h33, 8'h50, 0, 0);
    wbuf(2, 8'd3); wbuf(3, 8'h01); wbuf(4, 8'h02); wbuf(5, 8'h03);
    run_msg(T_WR, 8'h04, 8'hFE, 0, 0);
    wbuf(2, 8'd5);
    for (int i = 3; i < 8; i++) wbuf(i, 8'($urandom));
    msg_type = T_WR; msg_page = 8'h09; msg_offset = 8'h20; msg_exec = 1;
    tick();
    msg_exec = 0;
    tick();
    rst_b = 0;
    tick();
    chk("rst_mid", outs(), 64'd0);
    rst_b = 1;
    wq.delete(); rq.delete(); rspq.delete();
    repeat (4) tick();
    chk("rst_quiet", 64'(wq.size() + rq.size() + rspq.size()), 64'd0);
    wbuf(2, 8'd7);
    run_msg(T_RD, 8'h12, 8'h34, 0, 0);
    for (int k = 0; k < 40; k++) begin
      typ = 8'($urandom_range(4));
      if (typ == 8'd4) typ = 8'($urandom_range(255, 4));
      cerr = $urandom_range(9) == 0;
      len = typ == T_BYTE ? int'($urandom_range(255)) : int'($urandom_range(6));
      wbuf(2, 8'(len));
      for (int i = 3; i < 10; i++) wbuf(i, 8'($urandom));
      pg = 8'($urandom);
      of = $urandom_range(1) ? 8'($urandom) : 8'($urandom_range(255, 250));
      rdy_pct = $urandom_range(100, 30);
      stall_n = $urandom_range(3);
      bad_idx = (len > 0 && $urandom_range(1) == 1) ? int'($urandom_range(len - 1)) : -1;
      run_msg(typ, pg, of, cerr, 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
